alu_issue_stage: RTL and testbench

//  ID/EX issue register that drives the ALU: decodes opcode/funct into the
//  4-bit ALU operation code, selects/extends operands and shamt, and

---
 rtl/alu_issue_if.sv | 32 +++
 rtl/alu_issue_stage.sv | 141 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Handshake and datapath bundle between decode, the ALU issue register and the ALU.
// Valid/ready: a word moves on a rising edge when in_valid && in_ready; in_ready drops while stalled or in reset.
interface alu_issue_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [3:0]        ALUOperation;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [4:0]        ALUShamt;
  logic              out_illegal;

  modport master (
    output in_valid, opcode, funct, shamt, imm16, rs_data, rt_data, stall, flush,
    input  in_ready, out_valid, ALUOperation, A, B, ALUShamt, out_illegal
  );

  modport slave (
    input  in_valid, opcode, funct, shamt, imm16, rs_data, rt_data, stall, flush,
    output in_ready, out_valid, ALUOperation, A, B, ALUShamt, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes opcode/funct into a 4-bit ALU op, selects operands,
// and registers them for one-cycle issue with stall hold and flush kill.
module alu_issue_stage #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_LUI = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;

  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [4:0]        shamt_q, shamt_d;

  logic [3:0]        dec_op;
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic [4:0]        dec_shamt;
  logic              dec_ok;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign imm_sext = {{(DATA_W-16){bus.imm16[15]}}, bus.imm16};
  assign imm_zext = {{(DATA_W-16){1'b0}}, bus.imm16};

  // Undecodable instructions still issue, as AND of zeros, so exception logic can see them.
  always_comb begin
    dec_op    = OP_AND;
    dec_a     = bus.rs_data;
    dec_b     = bus.rt_data;
    dec_shamt = 5'd0;
    dec_ok    = 1'b1;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h24:        dec_op = OP_AND;
          6'h25:        dec_op = OP_OR;
          6'h27:        dec_op = OP_NOR;
          6'h20, 6'h21: dec_op = OP_ADD;
          6'h22, 6'h23: dec_op = OP_SUB;
          6'h00: begin
            dec_op    = OP_SLL;
            dec_shamt = bus.shamt;
          end
          6'h02: begin
            dec_op    = OP_SRL;
            dec_shamt = bus.shamt;
          end
          default:      dec_ok = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin
        dec_op = OP_ADD;
        dec_b  = imm_sext;
      end
      6'h0C: begin
        dec_op = OP_AND;
        dec_b  = imm_zext;
      end
      6'h0D: begin
        dec_op = OP_OR;
        dec_b  = imm_zext;
      end
      6'h0F: begin
        dec_op = OP_LUI;
        dec_b  = imm_zext;
      end
      6'h04, 6'h05: dec_op = OP_SUB;
      default:      dec_ok = 1'b0;
    endcase
    if (!dec_ok) begin
      dec_op    = OP_AND;
      dec_a     = '0;
      dec_b     = '0;
      dec_shamt = 5'd0;
    end
  end

  // Edge priority: flush, then stall, then load, else bubble; bubbles keep the data regs.
  always_comb begin
    valid_d   = valid_q;
    illegal_d = illegal_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    shamt_d   = shamt_q;
    if (bus.flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (bus.stall) begin
      valid_d   = valid_q;
    end else if (bus.in_valid) begin
      valid_d   = 1'b1;
      illegal_d = ~dec_ok;
      op_d      = dec_op;
      a_d       = dec_a;
      b_d       = dec_b;
      shamt_d   = dec_shamt;
    end else begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= 4'b0000;
      a_q       <= '0;
      b_q       <= '0;
      shamt_q   <= 5'd0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      shamt_q   <= shamt_d;
    end
  end

  assign bus.in_ready     = reset & ~bus.stall;
  assign bus.out_valid    = valid_q;
  assign bus.out_illegal  = illegal_q;
  assign bus.ALUOperation = op_q;
  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.ALUShamt     = shamt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage: a cycle-level reference model pushes the expected
// output state for every clock edge; a monitor pops and compares after each edge.
module tb_alu_issue_stage;
  localparam int DATA_W = 32;
  localparam int EW = 1 + 1 + 4 + DATA_W + DATA_W + 5 + 1;

  typedef struct packed {
    logic              ready;
    logic              valid;
    logic              illegal;
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        shamt;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_issue_if #(.DATA_W(DATA_W)) ifc ();

  alu_issue_stage #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc.slave)
  );

  logic [EW-1:0] exp_q[$];
  int   total;
  int   passed;
  exp_t model;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  // Reference model: what the ALU should be told for an instruction, straight from the op tables.
  function automatic exp_t ref_issue(input logic [5:0] opc, input logic [5:0] fn,
                                     input logic [4:0] sh, input logic [15:0] imm,
                                     input logic [31:0] rs, input logic [31:0] rt);
    exp_t r;
    logic [31:0] sx;
    logic [31:0] zx;
    sx = 32'($signed(imm));
    zx = 32'(imm);
    r = '0;
    r.valid = 1'b1;
    if (opc == 6'h00 && fn inside {6'h24, 6'h25, 6'h27, 6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h02}) begin
      r.a = rs;
      r.b = rt;
      if (fn == 6'h24)                       r.op = 4'd0;
      else if (fn == 6'h25)                  r.op = 4'd1;
      else if (fn == 6'h27)                  r.op = 4'd2;
      else if (fn == 6'h20 || fn == 6'h21)   r.op = 4'd3;
      else if (fn == 6'h22 || fn == 6'h23)   r.op = 4'd9;
      else begin
        r.op    = (fn == 6'h00) ? 4'd4 : 4'd5;
        r.shamt = sh;
      end
    end else if (opc inside {6'h08, 6'h09, 6'h23, 6'h2B}) begin
      r.op = 4'd3; r.a = rs; r.b = sx;
    end else if (opc == 6'h0C) begin
      r.op = 4'd0; r.a = rs; r.b = zx;
    end else if (opc == 6'h0D) begin
      r.op = 4'd1; r.a = rs; r.b = zx;
    end else if (opc == 6'h0F) begin
      r.op = 4'd8; r.a = rs; r.b = {16'h0, imm};
    end else if (opc == 6'h04 || opc == 6'h05) begin
      r.op = 4'd9; r.a = rs; r.b = rt;
    end else begin
      r.illegal = 1'b1;
    end
    return r;
  endfunction

  // driver: apply one cycle of inputs and push the state expected after the next edge
  task automatic drive(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic st, input logic fl);
    exp_t nxt;
    @(negedge clk);
    ifc.in_valid = v;  ifc.opcode = opc; ifc.funct = fn; ifc.shamt = sh;
    ifc.imm16 = imm;   ifc.rs_data = rs; ifc.rt_data = rt;
    ifc.stall = st;    ifc.flush = fl;
    nxt = model;
    if (fl) begin
      nxt.valid = 1'b0; nxt.illegal = 1'b0;
    end else if (!st) begin
      if (v) nxt = ref_issue(opc, fn, sh, imm, rs, rt);
      else begin
        nxt.valid = 1'b0; nxt.illegal = 1'b0;
      end
    end
    nxt.ready = ~st;
    model = nxt;
    exp_q.push_back(EW'(nxt));
  endtask

  // Reset pulse that lands between edges while the stage is stalled.
  task automatic reset_mid_stall();
    exp_t z;
    @(negedge clk);
    ifc.stall = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_async_op",    32'(ifc.ALUOperation), 32'd0);
    check("rst_async_a",     ifc.A, 32'd0);
    check("rst_async_b",     ifc.B, 32'd0);
    check("rst_async_ready", 32'(ifc.in_ready), 32'd0);
    z = '0;
    model = z;
    exp_q.push_back(EW'(z));
    @(negedge clk);
    ifc.stall = 1'b0;
    ifc.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        check("ready",   32'(ifc.in_ready),     32'(e.ready));
        check("valid",   32'(ifc.out_valid),    32'(e.valid));
        check("illegal", 32'(ifc.out_illegal),  32'(e.illegal));
        check("op",      32'(ifc.ALUOperation), 32'(e.op));
        check("a",       ifc.A,                 e.a);
        check("b",       ifc.B,                 e.b);
        check("shamt",   32'(ifc.ALUShamt),     32'(e.shamt));
        if (ifc.ALUOperation == 4'b0111) check("op_0111", 32'(ifc.ALUOperation), 32'd0);
      end
    end
  end

  // stimulus
  initial begin
    logic [5:0] r_ops[9];
    logic [5:0] i_ops[9];
    logic [5:0] opc;
    logic [5:0] fn;
    total = 0;
    passed = 0;
    model = '0;
    r_ops = '{6'h24, 6'h25, 6'h27, 6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h02};
    i_ops = '{6'h08, 6'h09, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05};
    rst_n = 1'b0;
    ifc.in_valid = 0; ifc.opcode = 0; ifc.funct = 0; ifc.shamt = 0; ifc.imm16 = 0;
    ifc.rs_data = 0;  ifc.rt_data = 0; ifc.stall = 0; ifc.flush = 0;
    #2;
    check("reset_valid",   32'(ifc.out_valid),   32'd0);
    check("reset_illegal", 32'(ifc.out_illegal), 32'd0);
    check("reset_ready",   32'(ifc.in_ready),    32'd0);
    check("reset_b",       ifc.B,                32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd0, 0, 0);           // ADDI
    drive(1, 6'h0D, 6'h00, 5'd0, 16'hABCD, 32'h10, 32'd0, 0, 0);          // ORI
    drive(1, 6'h00, 6'h00, 5'd4, 16'h0100, 32'h3, 32'h1, 0, 0);          // SLL
    drive(1, 6'h0F, 6'h00, 5'd0, 16'h1234, 32'h0, 32'h0, 0, 0);          // LUI
    for (int i = 0; i < 3; i++)
      drive(1, 6'h08, 6'h00, 5'd0, 16'h0001, 32'h9, 32'h9, 1, 0);        // stalled
    drive(1, 6'h09, 6'h00, 5'd0, 16'h7777, 32'h5, 32'h6, 1, 1);          // flush wins
    drive(1, 6'h0C, 6'h00, 5'd0, 16'h8001, 32'hFFFF0000, 32'h0, 0, 0);  // ANDI
    drive(1, 6'h3F, 6'h00, 5'd0, 16'h5555, 32'h1111, 32'h2222, 0, 0);   // illegal
    drive(0, 6'h00, 6'h00, 5'd0, 16'h0000, 32'h0, 32'h0, 0, 0);         // bubble
    drive(1, 6'h00, 6'h02, 5'd31, 16'h0000, 32'hAAAA, 32'hF0, 0, 0);    // SRL
    drive(1, 6'h0F, 6'h00, 5'd0, 16'h4321, 32'h0, 32'h0, 0, 0);
    drive(1, 6'h08, 6'h00, 5'd0, 16'h0002, 32'h1, 32'h1, 1, 0);
    reset_mid_stall();
    drive(1, 6'h04, 6'h00, 5'd0, 16'h0010, 32'h77, 32'hDEAD, 0, 0);     // BEQ

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        opc = 6'h00;
        fn  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : r_ops[$urandom_range(0, 8)];
      end else begin
        opc = ($urandom_range(0, 5) == 0) ? 6'($urandom) : i_ops[$urandom_range(0, 8)];
        fn  = 6'($urandom);
      end
      drive(1'($urandom_range(0, 3) != 0), opc, fn, 5'($urandom), 16'($urandom),
            $urandom, $urandom, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
    end
    drive(0, 6'h00, 6'h00, 5'd0, 16'h0, 32'h0, 32'h0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
